// File: rtl/cpu_seq_pkg.sv
`default_nettype none
// cpu_seq_pkg: opcodes, NOP encoding and FSM state type shared by the program sequencer.
// Rev 1.0

package cpu_seq_pkg;

    localparam logic [3:0] OPC_JMP  = 4'hC;
    localparam logic [3:0] OPC_JZ   = 4'hD;
    localparam logic [3:0] OPC_RSVD = 4'hE;
    localparam logic [3:0] OPC_HALT = 4'hF;

    localparam logic [7:0] CPU_NOP  = 8'h00;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_DONE  = 2'd3
    } seq_state_t;

    // Opcodes 0xC..0xF are handled by the sequencer and never reach the core.
    function automatic logic is_local_op(input logic [3:0] opc);
        return (opc == OPC_JMP) || (opc == OPC_JZ) ||
               (opc == OPC_RSVD) || (opc == OPC_HALT);
    endfunction

endpackage

`default_nettype wire

// File: rtl/cpu_program_sequencer.sv
`default_nettype none
// cpu_program_sequencer: fetches instructions, issues ALU ops to the core, runs JMP/JZ/HALT locally.
// Rev 1.0

module cpu_program_sequencer
    import cpu_seq_pkg::*;
#(
    parameter int PC_W      = 4,
    parameter int INSN_W    = 8,
    parameter int MAX_INSNS = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [PC_W-1:0]   start_pc,
    output logic              imem_req,
    output logic [PC_W-1:0]   imem_addr,
    input  logic [INSN_W-1:0] imem_rdata,
    input  logic              imem_valid,
    output logic [INSN_W-1:0] cpu_instruction,
    input  logic [7:0]        cpu_acc,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [PC_W-1:0]   pc,
    output logic [7:0]        insn_count
);

    localparam int OPND_W = INSN_W - 4;

    seq_state_t        state;
    seq_state_t        state_nxt;
    logic [INSN_W-1:0] insn;
    logic [3:0]        opcode;
    logic [PC_W-1:0]   operand_pc;
    logic [PC_W-1:0]   pc_inc;
    logic [PC_W-1:0]   pc_nxt;
    logic [7:0]        count_inc;
    logic              is_halt;
    logic              is_alu;
    logic              watchdog;

    // Decode of the latched instruction; only meaningful while in EXEC.
    assign opcode     = insn[INSN_W-1 -: 4];
    assign operand_pc = PC_W'(insn[OPND_W-1:0]);
    assign pc_inc     = pc + PC_W'(1);
    assign is_halt    = (opcode == OPC_HALT);
    assign is_alu     = !is_local_op(opcode);
    assign count_inc  = (insn_count == 8'hFF) ? 8'hFF : insn_count + 8'd1;
    assign watchdog   = !is_halt && (int'(count_inc) >= MAX_INSNS);
    assign imem_addr  = pc;

    always_comb begin
        pc_nxt = pc_inc;
        case (opcode)
            OPC_JMP:  pc_nxt = operand_pc;
            OPC_JZ:   pc_nxt = (cpu_acc == 8'd0) ? operand_pc : pc_inc;
            OPC_HALT: pc_nxt = pc;
            default:  pc_nxt = pc_inc;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Outputs are decoded from state so an async reset forces them low at once.
    always_comb begin
        state_nxt       = state;
        imem_req        = 1'b0;
        busy            = 1'b1;
        done            = 1'b0;
        cpu_instruction = INSN_W'(CPU_NOP);
        case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_nxt = ST_FETCH;
                end
            end
            ST_FETCH: begin
                imem_req = 1'b1;
                if (imem_valid) begin
                    state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (is_alu) begin
                    cpu_instruction = insn;
                end
                state_nxt = (is_halt || watchdog) ? ST_DONE : ST_FETCH;
            end
            ST_DONE: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc         <= '0;
            insn_count <= 8'd0;
            insn       <= INSN_W'(CPU_NOP);
            err        <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        pc         <= start_pc;
                        insn_count <= 8'd0;
                        err        <= 1'b0;
                    end
                end
                ST_FETCH: begin
                    if (imem_valid) begin
                        insn <= imem_rdata;
                    end
                end
                ST_EXEC: begin
                    insn_count <= count_inc;
                    pc         <= pc_nxt;
                    if (watchdog) begin
                        err <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_cpu_program_sequencer.sv
`default_nettype none
// tb_cpu_program_sequencer: scoreboarded bench with a memory responder and a tiny accumulator core.
// Rev 1.0

module tb_cpu_program_sequencer;

    logic       clk      = 1'b0;
    logic       reset    = 1'b0;
    logic       start    = 1'b0;
    logic       start_wd = 1'b0;
    logic [3:0] start_pc = 4'd0;
    logic       core_clr = 1'b0;
    logic [7:0] mem [16];
    int         fetch_delay = 0;

    logic       imem_req, imem_valid, busy, done, err;
    logic [3:0] imem_addr, pc;
    logic [7:0] imem_rdata, cpu_instruction, insn_count;
    logic [7:0] acc = 8'd0;
    int         wcnt = 0;

    logic       wd_imem_req, wd_imem_valid, wd_busy, wd_done, wd_err;
    logic [3:0] wd_imem_addr, wd_pc;
    logic [7:0] wd_imem_rdata, wd_cpu_instruction, wd_insn_count;
    int         wd_wcnt = 0;

    int         total = 0;
    int         bad = 0;
    logic [7:0] exp_q [$];
    logic [7:0] exp_i;
    logic [7:0] prev_ins = 8'd0;
    int         done_cnt = 0;
    int         fetch_cnt = 0;

    always #5 clk = ~clk;

    cpu_program_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .start_pc(start_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .imem_valid(imem_valid), .cpu_instruction(cpu_instruction), .cpu_acc(acc),
        .busy(busy), .done(done), .err(err), .pc(pc), .insn_count(insn_count)
    );

    cpu_program_sequencer #(.MAX_INSNS(8)) dut_wd (
        .clk(clk), .reset(reset), .start(start_wd), .start_pc(4'd0),
        .imem_req(wd_imem_req), .imem_addr(wd_imem_addr), .imem_rdata(wd_imem_rdata),
        .imem_valid(wd_imem_valid), .cpu_instruction(wd_cpu_instruction), .cpu_acc(acc),
        .busy(wd_busy), .done(wd_done), .err(wd_err), .pc(wd_pc), .insn_count(wd_insn_count)
    );

    // Memory responder: valid after fetch_delay waiting cycles of an outstanding request.
    assign imem_rdata    = mem[imem_addr];
    assign imem_valid    = imem_req && (wcnt >= fetch_delay);
    assign wd_imem_rdata = mem[wd_imem_addr];
    assign wd_imem_valid = wd_imem_req && (wd_wcnt >= fetch_delay);

    always @(posedge clk) begin
        wcnt    <= (imem_req && !imem_valid) ? wcnt + 1 : 0;
        wd_wcnt <= (wd_imem_req && !wd_imem_valid) ? wd_wcnt + 1 : 0;
    end

    // Accumulator core: opcode 0 = ADD, 1 = SUB, everything else leaves acc alone.
    always @(posedge clk) begin
        if (core_clr)
            acc <= 8'd0;
        else if (cpu_instruction[7:4] == 4'h0)
            acc <= acc + {4'h0, cpu_instruction[3:0]};
        else if (cpu_instruction[7:4] == 4'h1)
            acc <= acc - {4'h0, cpu_instruction[3:0]};
    end

    // Issue monitor: every non-NOP must match the scoreboard and follow a NOP cycle.
    always @(negedge clk) begin
        if (reset) begin
            if (cpu_instruction !== 8'h00) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL issue_unexpected got=%h expected=none", cpu_instruction);
                end else begin
                    exp_i = exp_q.pop_front();
                    if (cpu_instruction !== exp_i) begin
                        bad++;
                        $display("FAIL issue_value got=%h expected=%h", cpu_instruction, exp_i);
                    end
                end
                total++;
                if (prev_ins !== 8'h00) begin
                    bad++;
                    $display("FAIL issue_spacing prev=%h expected=00", prev_ins);
                end
            end
            if (done === 1'b1) done_cnt++;
            if (imem_req === 1'b1 && imem_valid === 1'b1) fetch_cnt++;
        end
        prev_ins = cpu_instruction;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    task automatic load(input logic [7:0] fill);
        for (int i = 0; i < 16; i++) mem[i] = fill;
    endtask

    task automatic clear_core();
        core_clr = 1'b1;
        @(negedge clk);
        core_clr = 1'b0;
    endtask

    // Starts the main DUT and returns at the negedge where done is seen.
    task automatic run_main(input logic [3:0] spc, input bit hold_start, input int budget);
        int n;
        start_pc = spc;
        start = 1'b1;
        @(negedge clk);
        if (!hold_start) start = 1'b0;
        n = 0;
        while (done !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        total++;
        if (done !== 1'b1) begin
            bad++;
            $display("FAIL run_timeout done=%b expected=1", done);
        end
    endtask

    task automatic test_reset();
        #1;
        total++;
        if ({imem_req, busy, done, err} !== 4'b0000 || pc !== 4'd0 ||
            insn_count !== 8'd0 || cpu_instruction !== 8'h00) begin
            bad++;
            $display("FAIL reset_state req/busy/done/err=%b%b%b%b pc=%0d cnt=%0d ins=%h expected all zero",
                     imem_req, busy, done, err, pc, insn_count, cpu_instruction);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_alu_issue();
        int db;
        load(8'hF0);
        mem[0] = 8'h01; mem[1] = 8'h01; mem[2] = 8'hF0;
        clear_core();
        exp_q.push_back(8'h01);
        exp_q.push_back(8'h01);
        db = done_cnt;
        run_main(4'd0, 1'b0, 50);
        total++;
        if (insn_count !== 8'd3 || err !== 1'b0 || pc !== 4'd2 || busy !== 1'b1) begin
            bad++;
            $display("FAIL alu_end cnt=%0d err=%b pc=%0d busy=%b expected 3 0 2 1", insn_count, err, pc, busy);
        end
        repeat (3) @(negedge clk);
        total++;
        if (acc !== 8'd2 || done_cnt - db !== 1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL alu_acc acc=%0d dones=%0d busy=%b expected 2 1 0", acc, done_cnt - db, busy);
        end
    endtask

    task automatic test_jz();
        load(8'hF0);
        mem[0] = 8'hD5; mem[5] = 8'hF0; mem[1] = 8'h11;
        clear_core();
        run_main(4'd0, 1'b0, 50);
        total++;
        if (pc !== 4'd5 || insn_count !== 8'd2) begin
            bad++;
            $display("FAIL jz_taken pc=%0d cnt=%0d expected 5 2", pc, insn_count);
        end
        @(negedge clk);
        load(8'hF0);
        mem[0] = 8'h01; mem[1] = 8'hD5; mem[2] = 8'hF0; mem[5] = 8'h11;
        exp_q.push_back(8'h01);
        run_main(4'd0, 1'b0, 50);
        total++;
        if (pc !== 4'd2 || insn_count !== 8'd3 || acc !== 8'd1) begin
            bad++;
            $display("FAIL jz_not_taken pc=%0d cnt=%0d acc=%0d expected 2 3 1", pc, insn_count, acc);
        end
        @(negedge clk);
    endtask

    task automatic test_watchdog();
        int n, dones, fetches;
        load(8'hF0);
        mem[0] = 8'hC0;
        start_wd = 1'b1;
        @(negedge clk);
        start_wd = 1'b0;
        n = 0; dones = 0; fetches = 0;
        if (wd_imem_req && wd_imem_valid) fetches++;
        while (wd_done !== 1'b1 && n < 100) begin
            @(negedge clk);
            if (wd_imem_req && wd_imem_valid) fetches++;
            n++;
        end
        total++;
        if (wd_done !== 1'b1 || wd_busy !== 1'b1 || wd_err !== 1'b1 || wd_insn_count !== 8'd8 || fetches != 8) begin
            bad++;
            $display("FAIL wd_abort done=%b busy=%b err=%b cnt=%0d fetches=%0d expected 1 1 1 8 8",
                     wd_done, wd_busy, wd_err, wd_insn_count, fetches);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (wd_done === 1'b1) dones++;
        end
        total++;
        if (dones != 0 || wd_busy !== 1'b0 || wd_err !== 1'b1) begin
            bad++;
            $display("FAIL wd_after extra_dones=%0d busy=%b err=%b expected 0 0 1", dones, wd_busy, wd_err);
        end
        mem[0] = 8'hF0;
        start_wd = 1'b1;
        @(negedge clk);
        start_wd = 1'b0;
        total++;
        if (wd_err !== 1'b0 || wd_busy !== 1'b1) begin
            bad++;
            $display("FAIL wd_err_clear err=%b busy=%b expected 0 1", wd_err, wd_busy);
        end
        repeat (6) @(negedge clk);
    endtask

    task automatic test_delayed_fetch();
        int n, fb;
        logic       waiting;
        logic [3:0] last_addr;
        load(8'hF0);
        mem[0] = 8'h01; mem[1] = 8'h02; mem[2] = 8'hF0;
        clear_core();
        fetch_delay = 3;
        exp_q.push_back(8'h01);
        exp_q.push_back(8'h02);
        fb = fetch_cnt;
        start_pc = 4'd0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0; waiting = 1'b0; last_addr = 4'd0;
        while (done !== 1'b1 && n < 100) begin
            if (imem_req === 1'b1 && imem_valid !== 1'b1) begin
                total++;
                if (cpu_instruction !== 8'h00 || (waiting && imem_addr !== last_addr)) begin
                    bad++;
                    $display("FAIL wait_stable ins=%h addr=%0d expected 00 and addr %0d",
                             cpu_instruction, imem_addr, last_addr);
                end
                waiting = 1'b1;
                last_addr = imem_addr;
            end else begin
                waiting = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        total++;
        if (done !== 1'b1 || fetch_cnt - fb != 3 || insn_count !== 8'd3 || n < 12) begin
            bad++;
            $display("FAIL delayed_run done=%b fetches=%0d cnt=%0d cycles=%0d expected 1 3 3 >=12",
                     done, fetch_cnt - fb, insn_count, n);
        end
        fetch_delay = 0;
        repeat (2) @(negedge clk);
        total++;
        if (acc !== 8'd3) begin
            bad++;
            $display("FAIL delayed_acc acc=%0d expected 3", acc);
        end
    endtask

    task automatic test_reset_mid_exec();
        int n;
        load(8'hF0);
        mem[0] = 8'h05; mem[1] = 8'hF0;
        clear_core();
        exp_q.push_back(8'h05);
        start_pc = 4'd0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (cpu_instruction === 8'h00 && n < 20) begin
            @(negedge clk);
            n++;
        end
        #2;
        reset = 1'b0;
        #1;
        total++;
        if (cpu_instruction !== 8'h00 || busy !== 1'b0 || pc !== 4'd0 || imem_req !== 1'b0 || n >= 20) begin
            bad++;
            $display("FAIL reset_mid_exec ins=%h busy=%b pc=%0d req=%b expected 00 0 0 0",
                     cpu_instruction, busy, pc, imem_req);
        end
        @(negedge clk);
        reset = 1'b1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL reset_issue_seen pending=%0d expected 0", exp_q.size());
            exp_q.delete();
        end
        load(8'hF0);
        mem[0] = 8'h02; mem[1] = 8'hF0;
        clear_core();
        exp_q.push_back(8'h02);
        run_main(4'd0, 1'b0, 50);
        repeat (2) @(negedge clk);
        total++;
        if (acc !== 8'd2 || insn_count !== 8'd2 || pc !== 4'd1) begin
            bad++;
            $display("FAIL restart acc=%0d cnt=%0d pc=%0d expected 2 2 1", acc, insn_count, pc);
        end
    endtask

    task automatic test_pc_wrap();
        int db;
        load(8'hF0);
        mem[15] = 8'h01; mem[0] = 8'hF0;
        clear_core();
        exp_q.push_back(8'h01);
        db = done_cnt;
        run_main(4'd15, 1'b1, 50);
        total++;
        if (pc !== 4'd0 || insn_count !== 8'd2 || err !== 1'b0) begin
            bad++;
            $display("FAIL wrap_end pc=%0d cnt=%0d err=%b expected 0 2 0", pc, insn_count, err);
        end
        repeat (4) @(negedge clk);
        total++;
        if (busy !== 1'b0 || done_cnt - db != 1 || acc !== 8'd1) begin
            bad++;
            $display("FAIL wrap_ignore_start busy=%b dones=%0d acc=%0d expected 0 1 1", busy, done_cnt - db, acc);
        end
    endtask

    initial begin
        load(8'hF0);
        test_reset();
        test_alu_issue();
        test_jz();
        test_watchdog();
        test_delayed_fetch();
        test_reset_mid_exec();
        test_pc_wrap();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL issues_missing pending=%0d expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
